// File: rtl/ps2_transmit.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ACK check.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a frame if the device stops clocking.
module ps2_transmit #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_CYCLES   = 50,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       in_clk,
  input  logic       in_reset_n,
  input  logic       in_ps2_clk,
  input  logic       in_ps2_data,
  input  logic       in_tx_valid,
  input  logic [7:0] in_tx_data,
  output logic       out_ps2_clk_oe,
  output logic       out_ps2_data_oe,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state, state_d;
  logic [2:0]       clk_sync, data_sync;
  logic             fall;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       edge_cnt, edge_d;
  logic [9:0]       frame, frame_d;
  logic             drive, drive_d;
  logic             ack_ok, ack_ok_d;
  logic             done_d, error_d;
  logic [WD_W-1:0]  wd, wd_d;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], in_ps2_clk};
      data_sync <= {data_sync[1:0], in_ps2_data};
    end
  end

  assign fall = (clk_sync[2:1] == 2'b10);

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      edge_cnt  <= '0;
      frame     <= '0;
      drive     <= 1'b0;
      ack_ok    <= 1'b0;
      out_done  <= 1'b0;
      out_error <= 1'b0;
      wd        <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      edge_cnt  <= edge_d;
      frame     <= frame_d;
      drive     <= drive_d;
      ack_ok    <= ack_ok_d;
      out_done  <= done_d;
      out_error <= error_d;
      wd        <= wd_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    edge_d   = edge_cnt;
    frame_d  = frame;
    drive_d  = drive;
    ack_ok_d = ack_ok;
    done_d   = 1'b0;
    error_d  = 1'b0;
    wd_d     = '0;
    case (state)
      S_IDLE: begin
        if (in_tx_valid) begin
          frame_d = {1'b1, ~^in_tx_data, in_tx_data};
          edge_d  = '0;
          cnt_d   = '0;
          drive_d = 1'b0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_START: begin
        // drive stays set across the clock release so the start bit is held until edge 1
        if (cnt == START_LAST) begin
          cnt_d   = '0;
          drive_d = 1'b1;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_SEND: begin
        if (fall) begin
          drive_d = ~frame[edge_cnt];
          edge_d  = edge_cnt + 1'b1;
          if (edge_cnt == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_ok_d = ~data_sync[2];
          state_d  = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync[2] && data_sync[2]) begin
          done_d  = ack_ok;
          error_d = ~ack_ok;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A normal completion in the same cycle as expiry takes precedence over the watchdog
    if (WD_EN && (state == S_SEND || state == S_ACK || state == S_WAIT_IDLE)) begin
      if (wd == WD_LAST && state_d != S_IDLE) begin
        state_d = S_IDLE;
        drive_d = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b1;
      end else begin
        wd_d = wd + 1'b1;
      end
    end
  end

  assign out_ps2_clk_oe  = (state == S_INHIBIT) || (state == S_START);
  assign out_ps2_data_oe = (state == S_START) || ((state == S_SEND) && drive);
  assign out_busy        = (state != S_IDLE);

endmodule

// File: doc/ps2_transmit.md
# ps2_transmit

Host-to-device PS/2 transmitter for the BU PACMAN keyboard path. Accepts one byte from core logic and sends it to the PS/2 device (e.g. reset 0xFF, set LEDs 0xED): inhibit, request-to-send, 8 data bits LSB-first, odd parity, stop, device ACK check. Drives the shared PS/2 clock and data lines open-drain through active-high pull-low enables, and sits beside ps2_receive on the same pins; the receiver must ignore traffic while out_busy is high.

## Interface
- INHIBIT_CYCLES, 5000: in_clk cycles the clock line is held low before the start bit (100 us at 50 MHz).
- START_CYCLES, 50: in_clk cycles data is held low with clock still low, before clock is released.
- TIMEOUT_CYCLES, 750000: watchdog limit, 15 ms at 50 MHz (used only with PS2_TX_TIMEOUT_EN).
- in_clk  input  1  system clock, all logic on rising edge.
- in_reset_n  input  1  asynchronous, active-low reset.
- in_ps2_clk  input  1  PS/2 clock line as seen on pin (unsynchronized).
- in_ps2_data  input  1  PS/2 data line as seen on pin (unsynchronized).
- in_tx_valid  input  1  request to send in_tx_data; sampled only in IDLE.
- in_tx_data  input  8  byte to send.
- out_ps2_clk_oe  output  1  1 = pull clock line low; 0 = release.
- out_ps2_data_oe  output  1  1 = pull data line low; 0 = release.
- out_busy  output  1  high from acceptance until return to IDLE.
- out_done  output  1  one-cycle pulse: byte sent and ACK received.
- out_error  output  1  one-cycle pulse: missing ACK or timeout.

## Operation
- in_ps2_clk and in_ps2_data each pass a 3-stage shift synchronizer; falling edge = stages [2:1] == 2'b10; data sampled from stage 2.
- Accept: IDLE and in_tx_valid=1 -> latch in_tx_data, compute odd parity (~^data), frame = {1'b1, parity, data}, edge counter = 0, go INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES, then START.
- START: clk_oe=1, data_oe=1 (start bit 0) for START_CYCLES, then release clock (clk_oe=0), go SEND.
- SEND: on each device falling edge n (n=1..10), drive frame bit n-1: data_oe = ~bit. Edge 10 drives stop bit (data_oe=0, released). Then ACK.
- ACK: on falling edge 11 sample data; 0 -> WAIT_IDLE with ack_ok; 1 -> WAIT_IDLE with ack_fail.
- WAIT_IDLE: wait until synchronized clock and data both 1, then pulse out_done (ack_ok) or out_error (ack_fail), go IDLE.
- Requests arriving while busy are ignored (not queued).
- Reset mid-frame: all enables released at once, state IDLE; the device treats the partial frame as aborted.

## Timing
- Reset values: out_ps2_clk_oe=0, out_ps2_data_oe=0, out_busy=0, out_done=0, out_error=0; state IDLE, counters 0.
- out_busy rises the cycle after in_tx_valid is sampled in IDLE; falls the same cycle out_done/out_error pulses.
- Line drive changes occur 3 in_clk cycles after the pin falling edge (synchronizer + edge detect), well inside the device low phase (>=30 us).
- out_done and out_error are mutually exclusive, each exactly one cycle.
- Clock line is never released before data has been low for START_CYCLES.

## Configuration
- PS2_TX_TIMEOUT_EN defined: a counter of TIMEOUT_CYCLES runs from entry to SEND; expiry before WAIT_IDLE completes releases both lines, pulses out_error, returns IDLE. Counter clears on return to IDLE.
- Undefined: no watchdog; a silent device holds the block in SEND/ACK until reset.

## Test plan
- Send 0xED with device model clocking at 12.5 kHz and ACKing -> bits 1,0,1,1,0,1,1,1 LSB-first, parity 1, stop 1 seen by model; out_done pulse, out_busy low after.
- Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; both complete with out_done.
- Device model does not pull data low at edge 11 -> out_error pulse, no out_done.
- in_tx_valid asserted again while busy with 0x55 -> ignored; only first byte transmitted.
- Assert in_reset_n=0 during bit 4 -> both oe drop to 0 asynchronously, out_busy=0; next request transmits cleanly.
- PS2_TX_TIMEOUT_EN defined, TIMEOUT_CYCLES=1000, device never clocks -> out_error pulse 1000 cycles after SEND entry, lines released.
